// File: rtl/io_bus_pkg.sv
// Shared bus definitions for the io_input_port responder and its bench.
// Contents: address/data widths, RSR bit positions, producer FSM state encoding.
// No ports; imported with io_bus_pkg::*.
package io_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Bit positions inside the receive status register
  localparam int RSR_FI   = 0;
  localparam int RSR_FULL = 1;

  // Producer handshake FSM, kept as plain constants for legacy tools
  typedef logic [0:0] prod_state_t;
  localparam prod_state_t WAIT_DAV  = 1'b0;
  localparam prod_state_t WAIT_HIGH = 1'b1;

endpackage

// File: rtl/io_input_port_if.sv
// Bus initiator and byte producer signals for io_input_port.
// Ports: addr, ior_, iow_ (bus strobes, active low), din, dav_ (producer), rfd (to producer).
// master = initiator/producer side, slave = io_input_port side.
interface io_input_port_if;
  import io_bus_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              ior_;
  logic              iow_;
  logic [DATA_W-1:0] din;
  logic              dav_;
  logic              rfd;

  modport master (output addr, ior_, iow_, din, dav_, input rfd);
  modport slave  (input addr, ior_, iow_, din, dav_, output rfd);

endinterface

// File: rtl/io_fifo.sv
// Small byte FIFO with same-edge push and pop; head is the oldest entry (combinational).
// Ports: clock, reset_ (async low), push/din, pop, head, count, empty, full.
// Caller guarantees no push when full and no pop when empty; DEPTH must be a power of two.
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clock,
  input  logic                   reset_,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/io_input_port.sv
// Bus-responder input port: bytes from a 4-phase dav_/rfd producer are queued and read via RSR/RBR.
// Ports: clock, reset_ (async low), bus (io_input_port_if.slave), data (tri-state read bus), intr.
// Optional IO_INPUT_PORT_INTR_EN adds the CTR register (ie bit) and the registered intr output.
module io_input_port
  import io_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RSR_ADDR = 16'h0100,
  parameter logic [ADDR_W-1:0] RBR_ADDR = 16'h0101,
  parameter logic [ADDR_W-1:0] CTR_ADDR = 16'h0102,
  parameter int                DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset_,
  io_input_port_if.slave    bus,
  inout  wire  [DATA_W-1:0] data
`ifdef IO_INPUT_PORT_INTR_EN
  ,
  output logic              intr
`endif
);

  logic [DATA_W-1:0]      head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   empty;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   pop_pend;
  logic                   rfd_q;
  prod_state_t            state;

  logic                   rsr_sel;
  logic                   rbr_sel;
  logic                   rd_en;
  logic [DATA_W-1:0]      rd_val;

  io_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_fifo (
    .clock (clock),
    .reset_(reset_),
    .push  (push),
    .din   (bus.din),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .empty (empty),
    .full  (full)
  );

  assign rsr_sel = !bus.ior_ && (bus.addr == RSR_ADDR);
  assign rbr_sel = !bus.ior_ && (bus.addr == RBR_ADDR);

`ifdef IO_INPUT_PORT_INTR_EN
  logic ie;
  logic ctr_sel;
  assign ctr_sel = !bus.ior_ && (bus.addr == CTR_ADDR);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ie   <= 1'b0;
      intr <= 1'b0;
    end else begin
      if (!bus.iow_ && (bus.addr == CTR_ADDR)) ie <= data[0];
      intr <= ie & !empty;
    end
  end
`endif

  // Read mux; the value depends only on inputs held stable during the strobe
  always_comb begin
    rd_en  = 1'b0;
    rd_val = '0;
    if (rsr_sel) begin
      rd_en            = 1'b1;
      rd_val[RSR_FI]   = !empty;
      rd_val[RSR_FULL] = full;
    end else if (rbr_sel) begin
      rd_en  = 1'b1;
      rd_val = empty ? '0 : head;
    end
`ifdef IO_INPUT_PORT_INTR_EN
    else if (ctr_sel) begin
      rd_en     = 1'b1;
      rd_val[0] = ie;
    end
`endif
  end

  assign data = rd_en ? rd_val : {DATA_W{1'bz}};

  // Pop is deferred to the strobe's rising edge so the initiator samples a stable head,
  // and a long strobe still removes exactly one entry.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_)               pop_pend <= 1'b0;
    else if (rbr_sel && !empty) pop_pend <= 1'b1;
    else if (bus.ior_)          pop_pend <= 1'b0;
  end

  assign pop  = pop_pend && bus.ior_;
  assign push = (state == WAIT_DAV) && !bus.dav_ && rfd_q && !full;

  // Producer handshake; while idle, rfd tracks the registered FULL flag so it
  // reopens one cycle after a pop frees a slot.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= WAIT_DAV;
      rfd_q <= 1'b1;
    end else if (state == WAIT_DAV) begin
      if (push) begin
        state <= WAIT_HIGH;
        rfd_q <= 1'b0;
      end else begin
        rfd_q <= !full;
      end
    end else if (bus.dav_) begin
      state <= WAIT_DAV;
      // No push in this state, so the FIFO is full next cycle only if full now and not popping
      rfd_q <= !(full && !pop);
    end
  end

  assign bus.rfd = rfd_q;

  // Signals not consumed in every build configuration
  logic unused_bits;
  assign unused_bits = &{1'b0, fifo_count, data, bus.iow_, CTR_ADDR};

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Bus-responder input interface: the target that an `ior_`/`iow_` bus initiator polls through a status register (RSR) and a receive buffer register (RBR).
- Bytes come in from an external producer over a 4-phase `dav_`/`rfd` handshake and are queued in a small FIFO.
- FIFO contents are exposed to the bus: RSR carries FI (data available) and FULL; reading RBR pops the FIFO.
- Two instances cover a typical system: RSR 16'h0100 / RBR 16'h0101, and RBR 16'h0120.

Parameters:
- RSR_ADDR, 16'h0100, bus address of the status register.
- RBR_ADDR, 16'h0101, bus address of the receive buffer register.
- CTR_ADDR, 16'h0102, bus address of the control register (used only with INTR_EN).
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_  in  1  asynchronous, active-low reset.
- addr  in  16  bus address from initiator.
- data  inout  8  bus data; driven only while this block is selected for a read, otherwise high-Z.
- ior_  in  1  read strobe, active low.
- iow_  in  1  write strobe, active low.
- din  in  8  producer byte.
- dav_  in  1  producer data-valid, active low.
- rfd  out  1  ready-for-data to producer.
- intr  out  1  interrupt request (present only with INTR_EN).

Behaviour:
- Reset (async, reset_=0): FIFO empty, rfd=1, producer FSM=WAIT_DAV, pop-pending=0, intr=0, ie=0, data high-Z.
- Bus read timing: address is stable ≥1 clock before ior_ falls; ior_ stays low ≥1 clock; the initiator samples data at the edge where it raises ior_.
- Read drive is combinational: data = RSR or RBR value whenever ior_=0 and addr matches. Value stays stable for the whole low phase.
- RSR = {6'b0, FULL, FI}, where FI = !empty and FULL = (count==DEPTH).
- RBR = FIFO head; 8'h00 when empty.
- RBR pop:
  - Posedge with ior_=0 and addr==RBR_ADDR and !empty sets pop-pending.
  - The first posedge with ior_=1 pops one entry and clears pop-pending.
  - Exactly one pop per strobe, whatever the strobe length.
  - Empty read: no pop, no underflow.
- RSR reads have no side effects.
- Producer FSM:
  - WAIT_DAV: on posedge with dav_=0, rfd=1 and !FULL → push din, rfd<=0, go to WAIT_HIGH.
  - WAIT_HIGH: on dav_=1 → go to WAIT_DAV, rfd<=!FULL_next.
  - While FULL in WAIT_DAV: rfd=0; rfd rises the cycle after a pop frees a slot.
  - dav_ is assumed synchronous to clock; no synchronizer.
- Simultaneous push and pop on the same edge: both happen; count unchanged; pointers wrap modulo DEPTH.
- Push into a FULL FIFO cannot occur (gated by rfd); assertion in the bench.
- Reset mid-read: pop-pending cleared and FIFO emptied; the next ior_ rise causes nothing.
- Writes (iow_) to RSR/RBR are ignored. Without INTR_EN, iow_ is ignored entirely.
- Count width: $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: IO_INPUT_PORT_INTR_EN.
- When defined:
  - Adds 1-bit control register ie at CTR_ADDR, readable as {7'b0, ie}.
  - Write takes effect at the first posedge with iow_=0 and addr match: ie<=data[0].
  - intr is registered: intr <= ie & FI.
- When undefined: no intr port, no CTR register, and a CTR_ADDR read leaves data high-Z.

Decomposition:
- Shared package io_bus_pkg:
  - Bus widths ADDR_W=16, DATA_W=8.
  - RSR bit indices RSR_FI=0, RSR_FULL=1.
  - Producer FSM state typedef {WAIT_DAV, WAIT_HIGH}.
- One sub-module, io_fifo: DEPTH-parameterised, push/pop/head/count/empty/full, same-edge push+pop supported.

Test Plan:
- Reset, then read RSR (addr 16'h0100, ior_ low 1 clk) → data=8'h00; rfd=1.
- Producer sends 8'hA5 (dav_ low until rfd falls, then high) → RSR reads 8'h01; RBR read returns 8'hA5; RSR afterward reads 8'h00.
- Producer sends 8'h11, 8'h22, 8'h33, 8'h44 with no bus reads → RSR=8'h03, rfd stays 0 on a fifth offer. One RBR read returns 8'h11 → rfd=1 next cycle, fifth byte 8'h55 accepted. Draining yields 22, 33, 44, 55.
- RBR read with ior_ held low 3 clocks while the FIFO holds 8'h11, 8'h22 → only 8'h11 popped; next read returns 8'h22. RBR read when empty → 8'h00, count stays 0.
- Push completes on the same edge as a pop, with count=2 → count stays 2, FIFO order preserved.
- With INTR_EN: write 8'h01 to 16'h0102, then push 8'h7E → intr=1 the cycle after FI rises. RBR read → intr=0 one cycle after the pop. Reset asserted mid-handshake → intr=0, rfd=1, RSR=8'h00.
